// File: rtl/seg_scan_pkg.sv
// Shared types and frame layout for the 7-segment/keypad scan master.
package seg_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DWELL
  } state_e;

  localparam int unsigned KEY_SEL_MSB = 7;
  localparam int unsigned KEY_SEL_LSB = 6;
  localparam int unsigned SCR_SEL_MSB = 5;
  localparam int unsigned SCR_SEL_LSB = 4;
  localparam int unsigned DIGIT_MSB   = 3;

  localparam int unsigned NUM_SLOTS = 4;

  typedef logic [1:0] slot_t;

  function automatic logic [7:0] make_frame(input slot_t slot, input logic [3:0] digit);
    logic [7:0] f;
    f = '0;
    f[KEY_SEL_MSB:KEY_SEL_LSB] = slot;
    f[SCR_SEL_MSB:SCR_SEL_LSB] = slot;
    f[DIGIT_MSB:0]             = digit;
    return f;
  endfunction

endpackage

// File: rtl/seg_scan_master_if.sv
// SPI link between the scan master and the 7-segment/keypad slave.
interface seg_scan_master_if;
  logic sck;
  logic mosi;
  logic en;
  logic miso;

  modport master (output sck, output mosi, output en, input miso);
  modport slave  (input sck, input mosi, input en, output miso);
endinterface

// File: rtl/key_debounce.sv
// Per-slot key debouncer: the state flips after DEBOUNCE consecutive disagreeing samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk,
  input  logic RESET,
  input  logic sample_valid,
  input  logic sample,
  output logic state,
  output logic changed
);

  logic       state_q;
  logic [2:0] cnt_q;

  // Strobe in the sample cycle; the owner registers it into its event output.
  assign changed = sample_valid && (sample != state_q) && ((cnt_q + 3'd1) == 3'(DEBOUNCE));
  assign state   = state_q;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sample_valid) begin
      if (sample == state_q) begin
        cnt_q <= '0;
      end else if (changed) begin
        state_q <= ~state_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_master.sv
// SPI scan master: cycles 4 digit slots, sends one byte per slot and debounces the keypad.
module seg_scan_master
  import seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DWELL    = 64,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      run,
  input  logic [15:0]               digits,
  seg_scan_master_if.master         spi,
  output logic [NUM_SLOTS-1:0]      key_state,
  output logic                      key_event,
  output logic [1:0]                key_idx,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);

  state_e          state_q;
  slot_t           slot_q;
  logic [7:0]      shreg_q;
  logic [2:0]      bitcnt_q;
  logic [CW-1:0]   cnt_q;
  logic            sck_q;
  logic            en_q;
  logic            frame_done_q;
  logic            busy_q;
  logic            key_event_q;
  logic [1:0]      key_idx_q;

  logic [7:0]            frame_d;
  logic [NUM_SLOTS-1:0]  changed;

  assign frame_d = make_frame(slot_q, digits[{slot_q, 2'b00} +: 4]);

  // mosi is the shift register MSB, so it is registered and clears with the register.
  assign spi.sck  = sck_q;
  assign spi.en   = en_q;
  assign spi.mosi = shreg_q[7];

  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign key_event  = key_event_q;
  assign key_idx    = key_idx_q;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      cnt_q        <= '0;
      sck_q        <= 1'b0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sck_q <= 1'b0;
          en_q  <= 1'b0;
          if (run) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          shreg_q  <= frame_d;
          en_q     <= 1'b1;
          sck_q    <= 1'b0;
          bitcnt_q <= 3'd7;
          cnt_q    <= '0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              // Falling sck edge: advance to the next bit or close the frame.
              sck_q <= 1'b0;
              if (bitcnt_q == 3'd0) begin
                en_q    <= 1'b0;
                shreg_q <= '0;
                state_q <= ST_SETTLE;
              end else begin
                bitcnt_q <= bitcnt_q - 3'd1;
                shreg_q  <= {shreg_q[6:0], 1'b0};
              end
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SAMPLE: begin
          frame_done_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= ST_DWELL;
        end
        ST_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_q   <= '0;
            slot_q  <= slot_q + 2'd1;
            busy_q  <= run;
            state_q <= run ? ST_LOAD : ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      key_event_q <= 1'b0;
      key_idx_q   <= '0;
    end else begin
      key_event_q <= |changed;
      if (|changed) begin
        key_idx_q <= slot_q;
      end
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_deb
    key_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk          (clk),
      .RESET        (RESET),
      .sample_valid ((state_q == ST_SAMPLE) && (slot_q == slot_t'(k))),
      .sample       (~spi.miso),
      .state        (key_state[k]),
      .changed      (changed[k])
    );
  end

endmodule

// File: tb/tb_seg_scan_master.sv
// Bench for seg_scan_master: slave model on the SPI link, vector table, directed and random frames.
module tb_seg_scan_master;

  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b0;
  logic [15:0] digits = 16'h4321;
  logic [3:0]  key_state;
  logic        key_event;
  logic [1:0]  key_idx;
  logic        frame_done;
  logic        busy;

  seg_scan_master_if spi();

  seg_scan_master #(
    .CLK_DIV (4),
    .SETTLE  (4),
    .DWELL   (64),
    .DEBOUNCE(DEB)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .run        (run),
    .digits     (digits),
    .spi        (spi),
    .key_state  (key_state),
    .key_event  (key_event),
    .key_idx    (key_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Slave: shift on sck rise, latch on en fall; key mux follows the latched column select.
  logic [7:0] sl_sh = '0;
  logic [7:0] sl_lat = '0;
  int         sl_bits = 0;
  logic [7:0] lat_q[$];
  int         bits_q[$];
  logic [3:0] key_phys = '0;

  always @(posedge spi.sck) begin
    sl_sh = {sl_sh[6:0], spi.mosi};
    sl_bits++;
  end
  always @(negedge spi.en) begin
    sl_lat = sl_sh;
    lat_q.push_back(sl_sh);
    bits_q.push_back(sl_bits);
    sl_bits = 0;
  end
  assign spi.miso = ~key_phys[sl_lat[7:6]];

  // Timestamp monitor, sampled on the inactive edge.
  int   cyc = 0, t_busy_rise = 0, t_busy_fall = 0, t_en_rise = 0, t_en_fall = 0, en_len = 0;
  int   fd_t = 0, fd_prev = 0, ev_cnt = 0;
  logic [1:0] ev_idx = '0;
  logic en_p = 1'b0, busy_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1 && busy_p === 1'b0) t_busy_rise = cyc;
    if (busy === 1'b0 && busy_p === 1'b1) t_busy_fall = cyc;
    if (spi.en === 1'b1 && en_p === 1'b0) t_en_rise = cyc;
    if (spi.en === 1'b0 && en_p === 1'b1) begin
      t_en_fall = cyc;
      en_len    = cyc - t_en_rise;
    end
    if (frame_done === 1'b1) begin
      fd_prev = fd_t;
      fd_t    = cyc;
    end
    if (key_event === 1'b1) begin
      ev_cnt++;
      ev_idx = key_idx;
    end
    en_p   = spi.en;
    busy_p = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: slot walks 0..3 per frame; a key flips after DEB consecutive disagreeing samples.
  int         mslot = 0;
  logic [3:0] mstate = '0;
  int         mrun[4] = '{0, 0, 0, 0};
  logic [7:0] last_byte = '0;

  task automatic model_reset();
    mslot  = 0;
    mstate = '0;
    for (int i = 0; i < 4; i++) mrun[i] = 0;
  endtask

  task automatic wait_en_high();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spi.en === 1'b1) return;
    end
    check("en rise timeout", 32'd0, 32'd1);
  endtask

  task automatic do_frame(input logic [15:0] dg);
    bit         ok;
    int         ev0;
    logic [1:0] s2;
    logic [7:0] exp_b;
    logic       smp;
    bit         exp_ev;
    ev0 = ev_cnt;
    ok  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("frame_done timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    @(negedge clk);
    s2    = 2'(mslot);
    exp_b = {s2, s2, dg[mslot*4 +: 4]};
    if (lat_q.size() == 0) begin
      check("latched byte present", 32'd0, 32'd1);
    end else begin
      last_byte = lat_q.pop_front();
      check("latched byte", 32'(last_byte), 32'(exp_b));
      check("sck rises per frame", 32'(bits_q.pop_front()), 32'd8);
    end
    smp    = key_phys[mslot];
    exp_ev = 0;
    if (smp != mstate[mslot]) begin
      mrun[mslot]++;
      if (mrun[mslot] == DEB) begin
        mstate[mslot] = ~mstate[mslot];
        mrun[mslot]   = 0;
        exp_ev        = 1;
      end
    end else begin
      mrun[mslot] = 0;
    end
    check("key_state", 32'(key_state), 32'(mstate));
    check("key_event count", 32'(ev_cnt - ev0), 32'(exp_ev));
    if (exp_ev) check("key_idx", 32'(ev_idx), 32'(mslot));
    mslot = (mslot + 1) % 4;
  endtask

  typedef struct {
    logic [15:0] dg;
    logic [31:0] bytes;   // {slot3, slot2, slot1, slot0}
  } vec_t;

  vec_t tbl[4];
  bit   bseq[5];

  initial begin
    int ev0;
    int idx;
    logic [15:0] dg_save;

    tbl[0] = '{dg: 16'h4321, bytes: 32'hF4A35201};
    tbl[1] = '{dg: 16'hFEDC, bytes: 32'hFFAE5D0C};
    tbl[2] = '{dg: 16'h0000, bytes: 32'hF0A05000};
    tbl[3] = '{dg: 16'h9A5B, bytes: 32'hF9AA550B};
    bseq   = '{1, 0, 1, 1, 1};

    #2 RESET = 1'b0;
    #20;
    check("reset sck", 32'(spi.sck), 32'd0);
    check("reset mosi", 32'(spi.mosi), 32'd0);
    check("reset en", 32'(spi.en), 32'd0);
    check("reset key_state", 32'(key_state), 32'd0);
    check("reset key_event", 32'(key_event), 32'd0);
    check("reset key_idx", 32'(key_idx), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    RESET = 1'b1;
    lat_q.delete();
    bits_q.delete();
    sl_bits = 0;
    repeat (5) @(negedge clk);
    check("idle busy with run=0", 32'(busy), 32'd0);
    check("idle en with run=0", 32'(spi.en), 32'd0);

    // Vector table: four digit patterns, one full scan each.
    for (int v = 0; v < 4; v++) begin
      digits = tbl[v].dg;
      if (v == 0) run = 1'b1;
      for (int s = 0; s < 4; s++) begin
        do_frame(tbl[v].dg);
        check("table byte", 32'(last_byte), 32'(tbl[v].bytes[8*s +: 8]));
        if (v == 0 && s == 0) begin
          check("en fall after LOAD", 32'(t_en_fall - t_busy_rise), 32'd65);
          check("en high length", 32'(en_len), 32'd64);
        end else begin
          check("frame period", 32'(fd_t - fd_prev), 32'd134);
        end
      end
    end

    // Slot 2 held for three scans, then released for three.
    digits   = 16'h4321;
    key_phys = 4'b0100;
    for (int sc = 0; sc < 3; sc++) begin
      ev0 = ev_cnt;
      for (int f = 0; f < 4; f++) do_frame(digits);
      check("press state", 32'(key_state), (sc == 2) ? 32'h4 : 32'h0);
      check("press events", 32'(ev_cnt - ev0), (sc == 2) ? 32'd1 : 32'd0);
      if (sc == 2) check("press idx", 32'(ev_idx), 32'd2);
    end
    key_phys = 4'b0000;
    for (int sc = 0; sc < 3; sc++) begin
      ev0 = ev_cnt;
      for (int f = 0; f < 4; f++) do_frame(digits);
      check("release state", 32'(key_state), (sc == 2) ? 32'h0 : 32'h4);
      check("release events", 32'(ev_cnt - ev0), (sc == 2) ? 32'd1 : 32'd0);
      if (sc == 2) check("release idx", 32'(ev_idx), 32'd2);
    end

    // Bounce on slot 1: miso 0,1,0,0,0 gives one event after the last sample.
    for (int sc = 0; sc < 5; sc++) begin
      key_phys[1] = bseq[sc];
      ev0 = ev_cnt;
      for (int f = 0; f < 4; f++) do_frame(digits);
      check("bounce state", 32'(key_state), (sc == 4) ? 32'h2 : 32'h0);
      check("bounce events", 32'(ev_cnt - ev0), (sc == 4) ? 32'd1 : 32'd0);
      if (sc == 4) check("bounce idx", 32'(ev_idx), 32'd1);
    end

    // run drops during slot 2's shift: frame completes, then idle; resume at slot 3.
    do_frame(digits);
    do_frame(digits);
    wait_en_high();
    repeat (20) @(negedge clk);
    run = 1'b0;
    do_frame(digits);
    check("stop frame byte", 32'(last_byte), 32'hA3);
    check("busy in dwell after stop", 32'(busy), 32'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    @(negedge clk);
    check("busy fall after en fall", 32'(t_busy_fall - t_en_fall), 32'd69);
    repeat (30) @(negedge clk);
    check("no frame while stopped", 32'(lat_q.size()), 32'd0);
    check("busy stays low", 32'(busy), 32'd0);
    run = 1'b1;
    do_frame(digits);
    check("resume byte", 32'(last_byte), 32'hF4);

    // Asynchronous reset mid-shift.
    wait_en_high();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 RESET = 1'b0;
    #1;
    check("async reset en", 32'(spi.en), 32'd0);
    check("async reset sck", 32'(spi.sck), 32'd0);
    check("async reset mosi", 32'(spi.mosi), 32'd0);
    check("async reset key_state", 32'(key_state), 32'd0);
    check("async reset key_idx", 32'(key_idx), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    RESET = 1'b1;
    lat_q.delete();
    bits_q.delete();
    sl_bits  = 0;
    key_phys = '0;
    model_reset();
    @(negedge clk);
    run = 1'b1;
    do_frame(digits);
    check("post-reset byte", 32'(last_byte), 32'h01);

    // Random keys and mid-frame digit changes against the reference.
    for (int i = 0; i < 60; i++) begin
      dg_save = digits;
      if ($urandom_range(1, 0) == 1) begin
        idx = int'($urandom_range(3, 0));
        key_phys[idx] = ~key_phys[idx];
      end
      wait_en_high();
      repeat ($urandom_range(60, 1)) @(negedge clk);
      digits = 16'($urandom);
      do_frame(dg_save);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_scan_master.md
Name: seg_scan_master

Overview:
- SPI master that drives the 7-segment/keypad SPI slave: SCK, MOSI, EN out; MISO in.
- Cycles continuously through 4 digit slots. Each frame sends one byte: [7:6] keypad column select = slot, [5:4] screen select = slot, [3:0] hex digit for that slot.
- After each frame, samples MISO as that slot's key level, debounces it, and reports key state and key press/release events to the host logic.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period (≥1).
- SETTLE, 4: clk cycles after EN falls before MISO is sampled (≥1).
- DWELL, 64: clk cycles each digit is displayed with EN low, after the sample (≥1).
- DEBOUNCE, 3: consecutive agreeing samples needed to change a key state (1..7).

Ports:
- clk  in  1  system clock
- RESET  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = scanning, 0 = stop at the next frame boundary
- digits  in  16  slot k digit = digits[4k+3:4k]
- sck  out  1  SPI clock, idles 0
- mosi  out  1  SPI data, MSB first
- en  out  1  frame enable; high during shift, its falling edge latches the slave
- miso  in  1  keypad mux output from slave; 0 = key pressed
- key_state  out  4  debounced pressed state per slot
- key_event  out  1  1-cycle pulse when any key_state bit changes
- key_idx  out  2  slot of the last event; valid with key_event
- frame_done  out  1  1-cycle pulse at the end of SAMPLE
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RESET=0, async): state IDLE; outputs sck, mosi, en, key_state, key_event, key_idx, frame_done, busy all 0; slot 0; all counters 0.
- IDLE: en=0, sck=0. If run=1, go to LOAD on the next clk.
- LOAD (1 cycle):
  - Snapshot byte = {slot, slot, digits[4*slot+:4]}.
  - Set en=1, mosi=byte[7], bit counter 7.
- SHIFT: per bit, sck=0 for CLK_DIV cycles, then sck=1 for CLK_DIV cycles.
  - The slave samples on the sck rising edge.
  - On each sck falling edge, mosi advances to the next lower bit.
  - After bit 0's high phase: sck=0, go to SETTLE.
  - Shift lasts 16*CLK_DIV cycles.
- SETTLE: en=0 on entry; this falling edge latches the slave and applies the new display and key mux. Hold for SETTLE cycles; mosi=0.
- SAMPLE (1 cycle):
  - Feed ~miso to the debouncer for this slot.
  - Pulse frame_done.
- DWELL: hold DWELL cycles, then slot = slot+1 mod 4 (3 wraps to 0).
  - If run=1, go to LOAD; otherwise go to IDLE. Slot is kept, so scanning resumes at the next slot.
- Frame length = 1 + 16*CLK_DIV + SETTLE + 1 + DWELL = 134 clk cycles at defaults.
- run going 0 mid-frame does not abort; the frame completes through DWELL.
- digits changing mid-frame has no effect on the current byte (LOAD snapshot).
- Debounce per slot: 3-bit counter.
  - Sample equal to key_state → counter clears.
  - Sample differs → counter increments. When it reaches DEBOUNCE: key_state[slot] toggles, counter clears, key_event=1 and key_idx=slot in the following cycle.
  - Only one slot is sampled per cycle, so events never coincide.
- Reset mid-frame: immediate return to reset values; en drops to 0 asynchronously. A partially received byte in the slave is then latched by that falling en edge, which is accepted; the next frame overwrites it.
- All outputs are registered.

Decomposition:
- Package seg_scan_pkg:
  - State enum {IDLE, LOAD, SHIFT, SETTLE, SAMPLE, DWELL}.
  - Frame field constants: KEY_SEL_MSB=7, KEY_SEL_LSB=6, SCR_SEL_MSB=5, SCR_SEL_LSB=4, DIGIT_MSB=3.
  - Slot count 4.
- Sub-module key_debounce: one per slot.
  - Ports: clk, RESET, sample_valid, sample, state, changed.
  - Parameterised by DEBOUNCE.

Test Plan:
- Reset then run=1, digits=16'h4321, miso=1: slot 0 byte 0x01 on mosi as bits 0,0,0,0,0,0,0,1 on sck rising edges → en low at cycle 65 after LOAD; slots 1, 2, 3 send 0x52, 0xA3, 0xF4; frame_done every 134 cycles.
- Slave model (8-bit shift on sck rise, latch on en fall) attached → latched bytes 0x01, 0x52, 0xA3, 0xF4, 0x01 repeat; screen-select field walks 0..3.
- Drive miso=0 only during slot 2's SAMPLE:
  - for 2 scans → no event;
  - on the 3rd scan → key_event=1, key_idx=2, key_state=4'b0100;
  - release for 3 scans → key_state=0 with a second event.
- Bounce: slot 1 sample sequence 0,1,0,0,0 → single event after the last 0; key_state[1]=1.
- Deassert run mid-SHIFT of slot 2 → frame completes, busy falls after DWELL; re-assert run → next LOAD sends slot 3 byte 0xF4.
- Assert RESET=0 mid-SHIFT → en, sck, mosi=0 within the same cycle (async); key_state=0; after release and run=1, the first byte is slot 0 (0x01).
